branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Produces the `PCsrc` / `PCTarget` redirect pair consumed by the PC generator. It is the resolving end of the fetch-redirect interface.
- Takes resolved branch/jump information from the execute stage and computes the target address.
- Issues the redirect, holding it while fetch is stalled, and drives the decode and execute flush signals.
- Also flags misaligned targets and keeps a saturating redirect counter for performance analysis.

Parameters:
- WIDTH, 32, address/data width of PC, immediate, rs1 and target.
- CNT_WIDTH, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage holds a valid instruction this cycle.
- ex_branch  in  1  instruction is a conditional branch.
- ex_jump  in  1  instruction is JAL or JALR.
- ex_jalr  in  1  jump target is register-relative (valid only with ex_jump).
- ex_cond  in  1  branch condition evaluated true (from ALU).
- ex_pc  in  WIDTH  PC of the execute-stage instruction.
- ex_imm  in  WIDTH  sign-extended immediate.
- ex_rs1  in  WIDTH  rs1 operand value.
- f_stall  in  1  fetch PC register is not advancing this cycle.
- PCsrc  out  1  select PCTarget as next PC.
- PCTarget  out  WIDTH  redirect address.
- flush_d  out  1  squash fetch/decode pipeline register.
- flush_e  out  1  squash decode/execute pipeline register.
- misalign_err  out  1  one-cycle pulse: taken target not 4-byte aligned.
- redirect_count  out  CNT_WIDTH  number of redirects issued, saturating.

Behaviour:
- Reset (async, immediate on rst rise):
  - State goes to IDLE.
  - PCsrc=0, PCTarget=0, flush_d=0, flush_e=0, misalign_err=0, redirect_count=0.
  - The pending-target register clears to 0.
- Target computation (combinational, modulo 2^WIDTH):
  - If ex_jalr: tgt = (ex_rs1 + ex_imm) with bit 0 forced to 0.
  - Otherwise: tgt = ex_pc + ex_imm.
- Taken resolution: take = ex_valid & (ex_jump | (ex_branch & ex_cond)).
- Misalignment: take with tgt[1]=1.
  - No redirect is issued and the state is unchanged.
  - misalign_err is registered, so it pulses in the following cycle.
- States:
  - IDLE:
    - take & aligned & !f_stall: PCsrc=1, PCTarget=tgt, flush_d=1, flush_e=1 in the same cycle (zero latency). Latch tgt into last_target; count++. Next state SHADOW.
    - take & aligned & f_stall: PCsrc=0. Latch tgt into pend. Next state PENDING.
    - Otherwise: PCsrc=0, PCTarget=last_target.
  - PENDING:
    - ex_* inputs are ignored; the older redirect wins.
    - While f_stall=1: PCsrc=0, no flushes.
    - First cycle f_stall=0: PCsrc=1, PCTarget=pend, flush_d=1, flush_e=1, count++. Next state SHADOW.
  - SHADOW:
    - Lasts exactly one cycle. ex_valid is ignored because the execute stage holds a squashed bubble.
    - PCsrc=0, flushes=0. Next state IDLE.
- PCTarget when PCsrc=0 equals last_target (the last issued target). It is stable and never X.
- redirect_count saturates at 2^CNT_WIDTH-1 and never wraps.
- f_stall has no effect in SHADOW.
- A misaligned take in PENDING or SHADOW is ignored, with no error pulse.
- rst asserted in PENDING: the pending redirect is discarded and no PCsrc pulse occurs after reset release.
- All outputs are glitch-free relative to clk. Combinational paths run from the ex_* inputs and f_stall only.

Test Plan:
- Conditional branch taken, no stall: ex_branch=1, ex_cond=1, ex_pc=0x100, ex_imm=0x20 -> same cycle PCsrc=1, PCTarget=0x120, flush_d=flush_e=1; next cycle all 0; redirect_count=1.
- JALR alignment: ex_jump=ex_jalr=1, ex_rs1=0x2001, ex_imm=0x10 -> PCTarget=0x2010 (bit 0 cleared), PCsrc=1.
- Stalled redirect: take with tgt=0x400 while f_stall=1 for 3 cycles -> PCsrc=0 for 3 cycles; a second take (tgt=0x800) during the stall is ignored; first unstalled cycle gives PCsrc=1, PCTarget=0x400.
- Misaligned target: ex_pc=0x100, ex_imm=0x6, branch taken -> PCsrc=0, no flush; misalign_err=1 exactly one cycle later; count unchanged.
- Back-to-back resolutions: taken jump, then taken branch in the next (SHADOW) cycle -> only the first redirect is issued; the second is ignored; count=1.
- Reset mid-PENDING plus saturation:
  - Assert rst asynchronously mid-PENDING -> outputs 0 immediately; no PCsrc after release.
  - With CNT_WIDTH=2, issue 5 redirects -> redirect_count=3.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// Fetch-redirect bus: the execute-stage resolution inputs and fetch stall come in,
// and the PC select, target and pipeline flushes go out.
interface branch_redirect_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             ex_valid;
   logic             ex_branch;
   logic             ex_jump;
   logic             ex_jalr;
   logic             ex_cond;
   logic [WIDTH-1:0] ex_pc;
   logic [WIDTH-1:0] ex_imm;
   logic [WIDTH-1:0] ex_rs1;
   logic             f_stall;
   logic             PCsrc;
   logic [WIDTH-1:0] PCTarget;
   logic             flush_d;
   logic             flush_e;

   modport master (
      output ex_valid, ex_branch, ex_jump, ex_jalr, ex_cond,
             ex_pc, ex_imm, ex_rs1, f_stall,
      input  PCsrc, PCTarget, flush_d, flush_e
   );

   modport slave (
      input  ex_valid, ex_branch, ex_jump, ex_jalr, ex_cond,
             ex_pc, ex_imm, ex_rs1, f_stall,
      output PCsrc, PCTarget, flush_d, flush_e
   );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Resolves taken branches/jumps into a PCsrc/PCTarget redirect, holding it across
// fetch stalls, flagging misaligned targets and counting issued redirects.
module branch_redirect_ctrl #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_redirect_ctrl_if.slave bus,
   output logic                 misalign_err,
   output logic [CNT_WIDTH-1:0] redirect_count
);
   typedef enum logic [1:0] {IDLE, PENDING, SHADOW} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     pend_q, pend_d;
   logic [WIDTH-1:0]     last_target_q, last_target_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 misalign_q, misalign_d;

   logic [WIDTH-1:0]     tgt_sum;
   logic [WIDTH-1:0]     tgt;
   logic                 take;
   logic                 issue;
   logic                 pcsrc;
   logic [WIDTH-1:0]     pctarget;
   logic                 flush;

   always_comb begin
      tgt_sum = bus.ex_jalr ? (bus.ex_rs1 + bus.ex_imm) : (bus.ex_pc + bus.ex_imm);
      tgt     = bus.ex_jalr ? {tgt_sum[WIDTH-1:1], 1'b0} : tgt_sum;
      take    = bus.ex_valid & (bus.ex_jump | (bus.ex_branch & bus.ex_cond));

      state_d       = state_q;
      pend_d        = pend_q;
      last_target_d = last_target_q;
      misalign_d    = 1'b0;
      issue         = 1'b0;
      pcsrc         = 1'b0;
      pctarget      = last_target_q;
      flush         = 1'b0;

      case (state_q)
         IDLE: begin
            if (take) begin
               if (tgt[1]) begin
                  misalign_d = 1'b1;
               end else if (!bus.f_stall) begin
                  pcsrc         = 1'b1;
                  pctarget      = tgt;
                  flush         = 1'b1;
                  last_target_d = tgt;
                  issue         = 1'b1;
                  state_d       = SHADOW;
               end else begin
                  pend_d  = tgt;
                  state_d = PENDING;
               end
            end
         end
         // The held redirect is older than anything now in execute, so ex_* is ignored.
         PENDING: begin
            if (!bus.f_stall) begin
               pcsrc         = 1'b1;
               pctarget      = pend_q;
               flush         = 1'b1;
               last_target_d = pend_q;
               issue         = 1'b1;
               state_d       = SHADOW;
            end
         end
         SHADOW: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      count_d = (issue && (count_q != {CNT_WIDTH{1'b1}})) ? count_q + 1'b1 : count_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         pend_q        <= '0;
         last_target_q <= '0;
         count_q       <= '0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         last_target_q <= last_target_d;
         count_q       <= count_d;
         misalign_q    <= misalign_d;
      end
   end

   assign bus.PCsrc      = pcsrc;
   assign bus.PCTarget   = pctarget;
   assign bus.flush_d    = flush;
   assign bus.flush_e    = flush;
   assign misalign_err   = misalign_q;
   assign redirect_count = count_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; a second instance with a 2-bit counter
// sees the same stimulus to exercise counter saturation.
module tb_branch_redirect_ctrl;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_redirect_ctrl_if #(.WIDTH(W)) bus ();
   branch_redirect_ctrl_if #(.WIDTH(W)) bus_s ();

   logic        misalign_err, misalign_err_s;
   logic [15:0] redirect_count;
   logic [1:0]  redirect_count_s;

   assign bus_s.ex_valid  = bus.ex_valid;
   assign bus_s.ex_branch = bus.ex_branch;
   assign bus_s.ex_jump   = bus.ex_jump;
   assign bus_s.ex_jalr   = bus.ex_jalr;
   assign bus_s.ex_cond   = bus.ex_cond;
   assign bus_s.ex_pc     = bus.ex_pc;
   assign bus_s.ex_imm    = bus.ex_imm;
   assign bus_s.ex_rs1    = bus.ex_rs1;
   assign bus_s.f_stall   = bus.f_stall;

   branch_redirect_ctrl #(.WIDTH(W), .CNT_WIDTH(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .misalign_err   (misalign_err),
      .redirect_count (redirect_count)
   );

   branch_redirect_ctrl #(.WIDTH(W), .CNT_WIDTH(2)) dut_sat (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus_s),
      .misalign_err   (misalign_err_s),
      .redirect_count (redirect_count_s)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of execute-stage inputs just after the falling edge.
   task automatic drive(input string name, input logic v, input logic br, input logic jp,
                        input logic jr, input logic cd, input logic [W-1:0] pc,
                        input logic [W-1:0] imm, input logic [W-1:0] rs1, input logic st);
      @(negedge clk);
      bus.ex_valid  = v;
      bus.ex_branch = br;
      bus.ex_jump   = jp;
      bus.ex_jalr   = jr;
      bus.ex_cond   = cd;
      bus.ex_pc     = pc;
      bus.ex_imm    = imm;
      bus.ex_rs1    = rs1;
      bus.f_stall   = st;
      #2;
      $display("txn %-10s v=%0b br=%0b jp=%0b jr=%0b c=%0b pc=%h imm=%h rs1=%h stall=%0b -> PCsrc=%0b PCTarget=%h fd=%0b fe=%0b mis=%0b cnt=%0d",
               name, v, br, jp, jr, cd, pc, imm, rs1, st,
               bus.PCsrc, bus.PCTarget, bus.flush_d, bus.flush_e, misalign_err, redirect_count);
   endtask

   task automatic idle(input logic st);
      drive("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, st);
   endtask

   initial begin
      bus.ex_valid = 1'b0; bus.ex_branch = 1'b0; bus.ex_jump = 1'b0; bus.ex_jalr = 1'b0;
      bus.ex_cond = 1'b0; bus.ex_pc = '0; bus.ex_imm = '0; bus.ex_rs1 = '0; bus.f_stall = 1'b0;

      // Reset state
      #3;
      check("rst_pcsrc", bus.PCsrc, 0);
      check("rst_target", bus.PCTarget, 0);
      check("rst_flush", {bus.flush_d, bus.flush_e}, 0);
      check("rst_count", redirect_count, 0);
      check("rst_mis", misalign_err, 0);
      @(negedge clk);
      rst = 1'b0;

      // Branch taken, no stall: zero-latency redirect then shadow
      drive("br_taken", 1, 1, 0, 0, 1, 32'h100, 32'h20, 0, 0);
      check("br_pcsrc", bus.PCsrc, 1);
      check("br_target", bus.PCTarget, 32'h120);
      check("br_flush_d", bus.flush_d, 1);
      check("br_flush_e", bus.flush_e, 1);
      idle(0);
      check("br_shadow_pcsrc", bus.PCsrc, 0);
      check("br_shadow_flush", {bus.flush_d, bus.flush_e}, 0);
      check("br_hold_target", bus.PCTarget, 32'h120);
      check("br_count", redirect_count, 1);

      // JALR clears bit 0 of rs1+imm
      drive("jalr", 1, 0, 1, 1, 0, 32'h0, 32'h10, 32'h2001, 0);
      check("jalr_pcsrc", bus.PCsrc, 1);
      check("jalr_target", bus.PCTarget, 32'h2010);
      idle(0);
      check("jalr_count", redirect_count, 2);

      // Stalled redirect to 0x400; a second take to 0x800 during the stall is ignored
      drive("stall_take", 1, 1, 0, 0, 1, 32'h300, 32'h100, 0, 1);
      check("stall1_pcsrc", bus.PCsrc, 0);
      check("stall1_flush", bus.flush_d, 0);
      drive("stall_2nd", 1, 1, 0, 0, 1, 32'h700, 32'h100, 0, 1);
      check("stall2_pcsrc", bus.PCsrc, 0);
      check("stall2_flush", bus.flush_e, 0);
      idle(1);
      check("stall3_pcsrc", bus.PCsrc, 0);
      drive("unstall", 1, 1, 0, 0, 1, 32'h700, 32'h100, 0, 0);
      check("unstall_pcsrc", bus.PCsrc, 1);
      check("unstall_target", bus.PCTarget, 32'h400);
      check("unstall_flush", {bus.flush_d, bus.flush_e}, 2'b11);
      idle(0);
      check("unstall_shadow", bus.PCsrc, 0);
      check("unstall_hold", bus.PCTarget, 32'h400);
      check("unstall_count", redirect_count, 3);

      // Misaligned target: no redirect, error pulse one cycle later
      drive("misalign", 1, 1, 0, 0, 1, 32'h100, 32'h6, 0, 0);
      check("mis_pcsrc", bus.PCsrc, 0);
      check("mis_flush", bus.flush_d, 0);
      check("mis_early", misalign_err, 0);
      idle(0);
      check("mis_pulse", misalign_err, 1);
      check("mis_count", redirect_count, 3);
      check("mis_target", bus.PCTarget, 32'h400);
      idle(0);
      check("mis_end", misalign_err, 0);

      // Back-to-back: jump, then a branch in the shadow cycle is ignored
      drive("b2b_jump", 1, 0, 1, 0, 0, 32'h1000, 32'h40, 0, 0);
      check("b2b_pcsrc1", bus.PCsrc, 1);
      check("b2b_target1", bus.PCTarget, 32'h1040);
      drive("b2b_branch", 1, 1, 0, 0, 1, 32'h2000, 32'h8, 0, 0);
      check("b2b_pcsrc2", bus.PCsrc, 0);
      check("b2b_target2", bus.PCTarget, 32'h1040);
      idle(0);
      check("b2b_pcsrc3", bus.PCsrc, 0);
      check("b2b_count", redirect_count, 4);

      // Async reset while PENDING discards the held redirect
      drive("pend_take", 1, 1, 0, 0, 1, 32'h400, 32'h100, 0, 1);
      idle(1);
      rst = 1'b1;
      #1;
      bus.f_stall = 1'b0;
      #1;
      check("prst_pcsrc", bus.PCsrc, 0);
      check("prst_target", bus.PCTarget, 0);
      check("prst_count", redirect_count, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(0);
      check("prst_rel1", bus.PCsrc, 0);
      idle(0);
      check("prst_rel2", bus.PCsrc, 0);
      check("prst_rel_target", bus.PCTarget, 0);

      // Five redirects: 16-bit counter reaches 5, 2-bit counter saturates at 3
      for (int i = 1; i <= 5; i++) begin
         drive("sat_jump", 1, 0, 1, 0, 0, 32'h10 * i, 32'h0, 0, 0);
         idle(0);
      end
      check("sat_main_count", redirect_count, 5);
      check("sat_small_count", redirect_count_s, 3);
      check("sat_target", bus.PCTarget, 32'h50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
